// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type and constants for the SPI slave receiver
package spi_pkg;

    localparam int         SPI_DATA_W = 16;
    localparam logic [1:0] SPI_MODE   = 2'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        OVERLEN = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchronizer with rise/fall detect on the last stage
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              hist_q;
    logic              hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        hist_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~hist_q;
    assign fall = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI mode-0 slave receiver: frame FSM, bit counter, shift and holding registers
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              ss_in,
    input  logic              mosi_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int              CNT_W      = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam int              FL_W       = $clog2(SYNC_STAGES + 2);
    localparam logic [FL_W-1:0] FLUSH_DONE = FL_W'(SYNC_STAGES + 1);

    logic sclk_rise, sclk_fall, ss_rise, ss_fall, sample_edge, armed;

    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    spi_state_e             state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      shreg_q, shreg_d;
    logic [FL_W-1:0]        flush_q, flush_d;
    logic                   good_q, good_d;
    logic                   bad_q, bad_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk_in),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ss_in),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    assign sample_edge = (SPI_MODE == 2'd0 || SPI_MODE == 2'd3) ? sclk_rise : sclk_fall;

    // After reset the SS chain holds its reset value, so a pin already low would look like
    // a falling edge; frame starts are ignored until every stage and the history are real samples.
    assign armed = (flush_q == FLUSH_DONE);

    always_comb begin
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
        flush_d     = armed ? flush_q : flush_q + FL_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        good_d    = 1'b0;
        bad_d     = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (ss_fall && armed) begin
                    state_d = ACTIVE;
                    shreg_d = '0;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    good_d    = (bit_cnt_q == CNT_FULL);
                    bad_d     = (bit_cnt_q != '0) && (bit_cnt_q < CNT_FULL);
                end else if (sample_edge) begin
                    shreg_d   = {shreg_q[DATA_W-2:0], mosi_sync_q[SYNC_STAGES-1]};
                    bit_cnt_d = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_FULL) begin
                        state_d = OVERLEN;
                    end
                end
            end
            OVERLEN: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    bad_d     = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Holding register: a completion may replace the word in the same cycle it is popped.
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = bad_q;
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (good_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_sync_q <= '0;
            flush_q     <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            good_q      <= 1'b0;
            bad_q       <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            flush_q     <= flush_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - directed self-checking bench for spi_slave_rx
module tb_spi_slave_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk_in;
    logic        ss_in;
    logic        mosi_in;
    logic        rx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    int total  = 0;
    int bad    = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    always #5 clk = ~clk;

    spi_slave_rx #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk_in   (sclk_in),
        .ss_in     (ss_in),
        .mosi_in   (mosi_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            mosi_in = w[15 - (i % 16)];
            wait_clks(4);
            sclk_in = 1'b1;
            wait_clks(4);
            sclk_in = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input int n);
        ss_in = 1'b0;
        wait_clks(4);
        spi_bits(w, n);
        wait_clks(4);
        ss_in = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        sclk_in  = 1'b0;
        ss_in    = 1'b1;
        mosi_in  = 1'b0;
        rx_ready = 1'b1;
        wait_clks(3);
        check_eq("rst_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_data", 32'(rx_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ferr", 32'(frame_err), 32'd0);
        check_eq("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        wait_clks(6);

        // good frame, consumer always ready; exact SS-rise latency
        ss_in = 1'b0;
        wait_clks(4);
        check_eq("t1_busy_on", 32'(busy), 32'd1);
        spi_bits(16'h38AA, 16);
        wait_clks(4);
        ss_in = 1'b1;
        wait_clks(3);
        check_eq("t1_busy_off", 32'(busy), 32'd0);
        check_eq("t1_valid_early", 32'(rx_valid), 32'd0);
        wait_clks(1);
        check_eq("t1_valid", 32'(rx_valid), 32'd1);
        check_eq("t1_data", 32'(rx_data), 32'h38AA);
        wait_clks(1);
        check_eq("t1_valid_pop", 32'(rx_valid), 32'd0);
        check_eq("t1_no_err", 32'(fe_cnt + ov_cnt), 32'd0);

        // overrun while holding register full
        rx_ready = 1'b0;
        send_frame(16'h2000, 16);
        wait_clks(8);
        check_eq("t2_valid", 32'(rx_valid), 32'd1);
        check_eq("t2_data", 32'(rx_data), 32'h2000);
        send_frame(16'h2800, 16);
        wait_clks(8);
        check_eq("t2_ovr", 32'(ov_cnt), 32'd1);
        check_eq("t2_data_kept", 32'(rx_data), 32'h2000);
        check_eq("t2_valid_kept", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        wait_clks(1);
        check_eq("t2_pop", 32'(rx_valid), 32'd0);

        // short and long frames
        send_frame(16'hABCD, 12);
        wait_clks(8);
        check_eq("t3_short_ferr", 32'(fe_cnt), 32'd1);
        check_eq("t3_short_valid", 32'(rx_valid), 32'd0);
        ss_in = 1'b0;
        wait_clks(4);
        spi_bits(16'h5A5A, 17);
        wait_clks(4);
        check_eq("t3_overlen", 32'(dut.state_q), 32'd2);
        check_eq("t3_overlen_busy", 32'(busy), 32'd1);
        ss_in = 1'b1;
        wait_clks(8);
        check_eq("t3_long_ferr", 32'(fe_cnt), 32'd2);
        check_eq("t3_long_valid", 32'(rx_valid), 32'd0);

        // empty frame
        ss_in = 1'b0;
        wait_clks(6);
        check_eq("t4_busy_low", 32'(busy), 32'd1);
        ss_in = 1'b1;
        wait_clks(8);
        check_eq("t4_busy_high", 32'(busy), 32'd0);
        check_eq("t4_no_pulse", 32'(fe_cnt + ov_cnt), 32'd3);
        check_eq("t4_valid", 32'(rx_valid), 32'd0);

        // reset in the middle of a frame
        rx_ready = 1'b0;
        ss_in = 1'b0;
        wait_clks(4);
        spi_bits(16'hFFFF, 8);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        check_eq("t5_rst_data", 32'(rx_data), 32'd0);
        check_eq("t5_rst_busy", 32'(busy), 32'd0);
        spi_bits(16'hFFFF, 8);
        wait_clks(4);
        check_eq("t5_tail_busy", 32'(busy), 32'd0);
        ss_in = 1'b1;
        wait_clks(8);
        check_eq("t5_tail_valid", 32'(rx_valid), 32'd0);
        check_eq("t5_tail_ferr", 32'(fe_cnt), 32'd2);
        send_frame(16'h3000, 16);
        wait_clks(8);
        check_eq("t5_next_valid", 32'(rx_valid), 32'd1);
        check_eq("t5_next_data", 32'(rx_data), 32'h3000);
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;

        // pop and push in the same cycle
        send_frame(16'h1234, 16);
        wait_clks(8);
        check_eq("t6_hold_data", 32'(rx_data), 32'h1234);
        send_frame(16'h5678, 16);
        wait_clks(3);
        check_eq("t6_pre_data", 32'(rx_data), 32'h1234);
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
        check_eq("t6_valid", 32'(rx_valid), 32'd1);
        check_eq("t6_data", 32'(rx_data), 32'h5678);
        wait_clks(2);
        check_eq("t6_no_ovr", 32'(ov_cnt), 32'd1);
        check_eq("t6_valid_held", 32'(rx_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI slave receiver that deserializes frames driven by the design's SPI master outputs (MOSI, SCLK, SS) back into parallel words in the `clk` domain. It oversamples the three SPI lines through synchronizers, captures MOSI on SCLK rising edges MSB-first (mode 0), and validates frame length on SS deassertion. Completed words are offered on a one-entry valid/ready output. It is the loopback/readback end of the DAC command link and feeds monitoring or memory logic.

## Interface
- `DATA_W`, 16: bits per frame; a frame is valid only if exactly `DATA_W` SCLK rising edges occur while SS is low.
- `SYNC_STAGES`, 2: flip-flop stages on each SPI input (≥2).
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `sclk_in`  in  1  SPI clock from master; asynchronous to `clk`.
- `ss_in`  in  1  SPI slave select, active-low; asynchronous.
- `mosi_in`  in  1  SPI serial data; asynchronous.
- `rx_data`  out  DATA_W  received word; stable while `rx_valid`=1.
- `rx_valid`  out  1  word available.
- `rx_ready`  in  1  consumer accepts word when `rx_valid && rx_ready`.
- `busy`  out  1  high in ACTIVE or OVERLEN state.
- `frame_err`  out  1  one-cycle pulse: frame ended with wrong bit count.
- `overrun`  out  1  one-cycle pulse: good frame dropped because holding register full.

## Operation
- Synchronizer reset values: SS stages 1, SCLK stages 0, MOSI stages 0. Edge detect compares last sync stage with one extra history register.
- States: IDLE, ACTIVE, OVERLEN.
  - IDLE: `bit_cnt`=0. SS falling edge -> ACTIVE, clear shift register.
  - ACTIVE: each SCLK rising edge shifts in synchronized MOSI (`shreg <= {shreg[DATA_W-2:0], mosi}`), `bit_cnt`+1. Edge number `DATA_W`+1 -> OVERLEN. SS rising edge -> IDLE, and evaluate frame.
  - OVERLEN: ignore SCLK; SS rising edge -> IDLE with `frame_err` pulse.
- Frame evaluation on SS rising edge in ACTIVE: `bit_cnt`==`DATA_W` -> completion; 1..`DATA_W`-1 -> `frame_err`; 0 -> ignored silently (no pulse).
- `bit_cnt` width `$clog2(DATA_W+2)`; saturates, never wraps.
- Completion: if holding empty, or `rx_ready` high in the same cycle (pop and push simultaneous), load `rx_data` and set `rx_valid`; no overrun. Otherwise keep old word, pulse `overrun`.
- `rx_valid` clears on handshake when no completion occurs that cycle.
- SCLK edge and SS rising edge detected in the same cycle: SS takes priority; the SCLK edge is discarded.
- Reset mid-frame: state IDLE, counters/flags cleared, `rx_valid` 0; remainder of the interrupted frame is ignored because ACTIVE is entered only on an SS falling edge.
- Reset values: `rx_data` 0, `rx_valid` 0, `busy` 0, `frame_err` 0, `overrun` 0.

## Timing
- Requirement on master: SCLK high and low phases each ≥ `SYNC_STAGES`+1 `clk` periods; MOSI stable ≥1 `clk` period around SCLK rise; SS high ≥ `SYNC_STAGES`+1 periods between frames.
- SCLK pin rise -> bit shifted: `SYNC_STAGES`+1 cycles.
- SS pin rise -> `rx_valid`/`frame_err`/`overrun`: `SYNC_STAGES`+2 cycles (first `clk` edge sampling high counted as 1).
- `busy` asserts the cycle after SS falling edge detection; deasserts with the IDLE transition.
- `frame_err` and `overrun` are exactly one cycle wide; never both in one cycle.

## Structure
- Shared package `spi_pkg`: state enum (IDLE, ACTIVE, OVERLEN), default `DATA_W`=16, SPI mode constant (mode 0).
- Sub-module `spi_sync_edge`: parameterized synchronizer + rise/fall detect with reset value parameter; instantiated for SCLK and SS; MOSI uses the synchronizer only.
- Top holds FSM, counter, shift register, holding register.

## Test plan
- Send 16'h38AA (master pattern 0011100010101010), `rx_ready`=1 -> one `rx_valid` cycle with `rx_data`=16'h38AA, no error pulses.
- Send 16'h2000 then 16'h2800 with `rx_ready`=0 -> first held at 16'h2000, second produces `overrun`, `rx_data` stays 16'h2000; raise `rx_ready` -> `rx_valid` falls.
- Frame of 12 SCLK edges -> `frame_err` pulse, `rx_valid` stays 0; frame of 17 edges -> `frame_err`, state passes through OVERLEN.
- SS low/high with zero SCLK edges -> no pulses, `busy` high only during SS low.
- Assert `rst` after 8 bits of 16'hFFFF, release while SS still low, finish frame -> no `rx_valid`, no `frame_err`; next full frame 16'h3000 received correctly.
- `rx_valid` held with 16'h1234, `rx_ready` asserted in the exact completion cycle of 16'h5678 -> `rx_data`=16'h5678, `rx_valid` stays 1, no `overrun`.
